// File: rtl/mux_n_to_1_seq_pkg.sv
// Shared constants and helpers for the registered N-to-1 mux.
// Holds the mode encodings and a clog2 whose result is never below 1.
package mux_seq_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // A one-bit select is still needed when only one index exists.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) begin
            res++;
        end
        return (res < 1) ? 1 : res;
    endfunction

endpackage

// File: rtl/mux_n_to_1_seq_rr_pick.sv
// Cyclic priority search: first eligible index at or after ptr, wrapping modulo INPUTS.
// Purely combinational; ptr must be < INPUTS.
module rr_pick
    import mux_seq_pkg::*;
#(
    parameter int  INPUTS    = 8,
    localparam int SEL_WIDTH = clog2(INPUTS)
) (
    input  logic [INPUTS-1:0]    elig,
    input  logic [SEL_WIDTH-1:0] ptr,
    output logic                 found,
    output logic [SEL_WIDTH-1:0] idx
);

    localparam logic [SEL_WIDTH:0] N_W = (SEL_WIDTH+1)'(INPUTS);

    logic [2*INPUTS-1:0]  doubled;
    logic [INPUTS-1:0]    rotated;
    logic [SEL_WIDTH-1:0] offset;
    logic [SEL_WIDTH:0]   sum;

    // Rotating the doubled vector puts the candidate at ptr in bit 0.
    assign doubled = {elig, elig} >> ptr;
    assign rotated = doubled[INPUTS-1:0];

    always_comb begin
        found  = 1'b0;
        offset = '0;
        for (int i = INPUTS - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                found  = 1'b1;
                offset = i[SEL_WIDTH-1:0];
            end
        end
        // ptr and offset are both below INPUTS, so one subtraction wraps.
        sum = {1'b0, ptr} + {1'b0, offset};
        if (sum >= N_W) begin
            sum = sum - N_W;
        end
        idx = sum[SEL_WIDTH-1:0];
    end

endmodule

// File: rtl/mux_n_to_1_seq.sv
// Registered N-to-1 mux with manual select or round-robin scan; one cycle from capture to out.
// Backpressure: while out_valid && !out_ready everything holds and in_ready stays low.
module mux_n_to_1_seq
    import mux_seq_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               INPUTS      = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    localparam int              SEL_WIDTH   = clog2(INPUTS)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [INPUTS*WIDTH-1:0]  in,
    input  logic [INPUTS-1:0]        in_valid,
    output logic [INPUTS-1:0]        in_ready,
    input  logic [INPUTS-1:0]        enable_mask,
    input  logic                     mode,
    input  logic [SEL_WIDTH-1:0]     select,
    output logic [WIDTH-1:0]         out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SEL_WIDTH-1:0]     out_channel,
    output logic                     select_error
);

    localparam logic [SEL_WIDTH:0]   N_W  = (SEL_WIDTH+1)'(INPUTS);
    localparam logic [SEL_WIDTH-1:0] LAST = SEL_WIDTH'(INPUTS - 1);

    logic [WIDTH-1:0]     out_q, out_d;
    logic                 out_valid_q, out_valid_d;
    logic [SEL_WIDTH-1:0] out_channel_q, out_channel_d;
    logic                 select_error_q, select_error_d;
    logic [SEL_WIDTH-1:0] scan_ptr_q, scan_ptr_d;

    logic [WIDTH-1:0]     chan [INPUTS];
    logic [INPUTS-1:0]    elig;
    logic                 load_en;
    logic                 sel_ok;
    logic                 sel_elig;
    logic                 rr_found;
    logic [SEL_WIDTH-1:0] rr_idx;
    logic [SEL_WIDTH-1:0] cap_idx;
    logic                 cap_vld;
    logic [WIDTH-1:0]     cap_dat;

    for (genvar k = 0; k < INPUTS; k++) begin : g_chan
        assign chan[k] = in[k*WIDTH +: WIDTH];
    end

    assign elig    = enable_mask & in_valid;
    assign load_en = !out_valid_q || out_ready;
    assign sel_ok  = {1'b0, select} < N_W;

    rr_pick #(
        .INPUTS (INPUTS)
    ) u_rr_pick (
        .elig  (elig),
        .ptr   (scan_ptr_q),
        .found (rr_found),
        .idx   (rr_idx)
    );

    always_comb begin
        cap_idx  = (mode == MODE_SCAN) ? rr_idx : select;
        cap_dat  = '0;
        sel_elig = 1'b0;
        // Out-of-range indices match no channel, so they never capture.
        for (int k = 0; k < INPUTS; k++) begin
            if (cap_idx == SEL_WIDTH'(k)) begin
                cap_dat  = chan[k];
                sel_elig = elig[k];
            end
        end
        cap_vld = (mode == MODE_SCAN) ? rr_found : sel_elig;

        out_d          = out_q;
        out_valid_d    = out_valid_q;
        out_channel_d  = out_channel_q;
        scan_ptr_d     = scan_ptr_q;
        select_error_d = 1'b0;
        in_ready       = '0;

        if (load_en) begin
            out_valid_d    = cap_vld;
            select_error_d = (mode == MODE_MANUAL) && !sel_ok;
            if (cap_vld) begin
                out_d         = cap_dat;
                out_channel_d = cap_idx;
                for (int k = 0; k < INPUTS; k++) begin
                    in_ready[k] = reset && (cap_idx == SEL_WIDTH'(k));
                end
                if (mode == MODE_SCAN) begin
                    scan_ptr_d = (cap_idx == LAST) ? '0 : cap_idx + SEL_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_q          <= RESET_VALUE;
            out_valid_q    <= 1'b0;
            out_channel_q  <= '0;
            select_error_q <= 1'b0;
            scan_ptr_q     <= '0;
        end else begin
            out_q          <= out_d;
            out_valid_q    <= out_valid_d;
            out_channel_q  <= out_channel_d;
            select_error_q <= select_error_d;
            scan_ptr_q     <= scan_ptr_d;
        end
    end

    assign out          = out_q;
    assign out_valid    = out_valid_q;
    assign out_channel  = out_channel_q;
    assign select_error = select_error_q;

endmodule

// File: tb/tb_mux_n_to_1_seq.sv
// Directed and random stimulus for mux_n_to_1_seq (WIDTH=8, INPUTS=5) against a behavioural model.
module tb_mux_n_to_1_seq;

    localparam int W  = 8;
    localparam int N  = 5;
    localparam int SW = 3;

    logic           clock = 1'b0;
    logic           reset;
    logic [N*W-1:0] in_dat;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [N-1:0]   enable_mask;
    logic           mode;
    logic [SW-1:0]  select;
    logic [W-1:0]   out;
    logic           out_valid;
    logic           out_ready;
    logic [SW-1:0]  out_channel;
    logic           select_error;

    int checks = 0;
    int errors = 0;

    // Reference state: what the consumer should see, plus the scan position.
    logic [W-1:0] m_out = 8'hA5;
    logic         m_vld = 1'b0;
    int           m_ch  = 0;
    logic         m_err = 1'b0;
    int           m_ptr = 0;

    always #5 clock = ~clock;

    mux_n_to_1_seq #(
        .WIDTH       (W),
        .INPUTS      (N),
        .RESET_VALUE (8'hA5)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .in           (in_dat),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .enable_mask  (enable_mask),
        .mode         (mode),
        .select       (select),
        .out          (out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_channel  (out_channel),
        .select_error (select_error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_out = 8'hA5;
        m_vld = 1'b0;
        m_ch  = 0;
        m_err = 1'b0;
        m_ptr = 0;
    endtask

    // Called just after a falling edge with inputs already driven; returns at the next falling edge.
    task automatic step();
        int         g;
        int         k;
        bit         load;
        logic [N-1:0] exp_rdy;
        g       = -1;
        exp_rdy = '0;
        load    = !m_vld || out_ready;
        if (load) begin
            if (mode == 1'b0) begin
                if (int'(select) < N && enable_mask[select] && in_valid[select]) g = int'(select);
            end else begin
                for (int i = 0; i < N; i++) begin
                    k = (m_ptr + i) % N;
                    if (g < 0 && enable_mask[k] && in_valid[k]) g = k;
                end
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        #1;
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge clock);
        m_err = load && (mode == 1'b0) && (int'(select) >= N);
        if (load) begin
            m_vld = (g >= 0);
            if (g >= 0) begin
                m_out = in_dat[g*W +: W];
                m_ch  = g;
                if (mode == 1'b1) m_ptr = (g + 1) % N;
            end
        end
        #1;
        check("out", 32'(out), 32'(m_out));
        check("out_valid", 32'(out_valid), 32'(m_vld));
        check("out_channel", 32'(out_channel), 32'(m_ch));
        check("select_error", 32'(select_error), 32'(m_err));
        @(negedge clock);
    endtask

    initial begin
        int seq [5] = '{0, 2, 4, 0, 2};

        reset       = 1'b0;
        in_dat      = '0;
        in_valid    = '0;
        enable_mask = '0;
        mode        = 1'b0;
        select      = '0;
        out_ready   = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_out", 32'(out), 32'h0A5);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_channel", 32'(out_channel), 32'd0);
        check("rst_error", 32'(select_error), 32'd0);
        reset = 1'b1;

        // Manual select of channel 3.
        for (int k = 0; k < N; k++) in_dat[k*W +: W] = 8'h10 + 8'(k);
        in_dat[3*W +: W] = 8'h3C;
        in_valid    = 5'h1F;
        enable_mask = 5'h1F;
        select      = 3'd3;
        out_ready   = 1'b1;
        #1;
        check("t2_in_ready", 32'(in_ready), 32'b01000);
        step();
        check("t2_out", 32'(out), 32'h3C);
        check("t2_channel", 32'(out_channel), 32'd3);
        check("t2_valid", 32'(out_valid), 32'd1);

        // Out-of-range select, then back in range but idle.
        select = 3'd6;
        step();
        check("t3_error", 32'(select_error), 32'd1);
        check("t3_valid", 32'(out_valid), 32'd0);
        check("t3_out_hold", 32'(out), 32'h3C);
        select   = 3'd3;
        in_valid = '0;
        step();
        check("t3_error_pulse", 32'(select_error), 32'd0);

        // Scan fairness over a sparse mask.
        mode        = 1'b1;
        in_valid    = 5'h1F;
        enable_mask = 5'b10101;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t4_scan_channel", 32'(out_channel), 32'(seq[i]));
        end

        // Backpressure holds the captured channel 2 word and the pointer.
        out_ready = 1'b0;
        repeat (3) step();
        check("t5_hold_channel", 32'(out_channel), 32'd2);
        enable_mask = 5'h1F;
        out_ready   = 1'b1;
        step();
        check("t5_next_channel", 32'(out_channel), 32'd3);

        // Nothing eligible, then only channel 0 (wraps from pointer 4).
        in_valid = '0;
        step();
        check("t6_empty_valid", 32'(out_valid), 32'd0);
        in_valid = 5'b00001;
        step();
        check("t6_wrap_channel", 32'(out_channel), 32'd0);
        check("t6_wrap_valid", 32'(out_valid), 32'd1);

        // Asynchronous reset while a word is held.
        in_valid = 5'h1F;
        step();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("t1_async_out", 32'(out), 32'h0A5);
        check("t1_async_valid", 32'(out_valid), 32'd0);
        check("t1_async_channel", 32'(out_channel), 32'd0);
        check("t1_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clock);
        #1;
        check("t1_in_ready_edge", 32'(in_ready), 32'd0);
        check("t1_valid_edge", 32'(out_valid), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        step();
        check("t1_first_channel", 32'(out_channel), 32'd0);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < N; k++) in_dat[k*W +: W] = 8'($urandom);
            in_valid    = 5'($urandom);
            enable_mask = ($urandom_range(0, 3) == 0) ? 5'h1F : 5'($urandom);
            mode        = ($urandom_range(0, 2) != 0);
            select      = 3'($urandom_range(0, 7));
            out_ready   = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_n_to_1_seq.md
Name: mux_n_to_1_seq

Overview:
Registered N-to-1 multiplexer: the parametrised successor of the fixed 8-input registered mux. It generalises to any channel count and width, and adds per-channel valid/ready handshake, an output valid/ready stall, a per-channel enable mask, and two modes: manual select, and round-robin scan. It sits between multiple producers and a single consumer register stage in the datapath.

Parameters:
WIDTH, 8, data bits per channel (>=1)
INPUTS, 8, number of channels (>=2; need not be a power of two)
RESET_VALUE, 0, value of out after reset (WIDTH bits)
SEL_WIDTH, clog2(INPUTS), localparam: select/pointer width, minimum 1

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (asserted when 0)
in  input  INPUTS*WIDTH  channel k occupies bits [(k+1)*WIDTH-1 : k*WIDTH]
in_valid  input  INPUTS  per-channel data valid
in_ready  output  INPUTS  one-hot, combinational; bit k is high in the cycle channel k is captured
enable_mask  input  INPUTS  channel k is eligible only when bit k = 1
mode  input  1  0 = MANUAL, 1 = SCAN
select  input  SEL_WIDTH  channel index used in MANUAL mode
out  output  WIDTH  registered selected data
out_valid  output  1  out holds an unconsumed word
out_ready  input  1  consumer accepts out
out_channel  output  SEL_WIDTH  index of the channel held in out
select_error  output  1  registered one-cycle pulse: MANUAL select >= INPUTS

Behaviour:
- Reset (reset=0, asynchronous): out=RESET_VALUE, out_valid=0, out_channel=0, select_error=0, scan_ptr=0. Release is synchronous to clock.
- load_en = !out_valid || out_ready. The register updates only when load_en=1. Otherwise out, out_valid, out_channel and scan_ptr hold, and in_ready=0.
- Latency: a channel captured at edge t drives out/out_valid after edge t.
- Eligible(k) = enable_mask[k] && in_valid[k].
- MANUAL mode, on load_en:
  - select < INPUTS and Eligible(select): out<=in[select], out_channel<=select, out_valid<=1, in_ready[select]=1.
  - select < INPUTS and not eligible: out_valid<=0; out and out_channel hold their old values.
  - select >= INPUTS: out_valid<=0, select_error<=1 for one cycle, in_ready=0.
- SCAN mode, on load_en: search k = scan_ptr, scan_ptr+1, ... cyclically modulo INPUTS for the first Eligible(k).
  - Found: capture k, scan_ptr <= (k+1) mod INPUTS, in_ready[k]=1.
  - None found: out_valid<=0; scan_ptr holds.
  - The wrap from INPUTS-1 goes to 0, including when INPUTS is not a power of two.
- select_error is 0 in every cycle other than the pulse. select is ignored in SCAN mode.
- Mode change takes effect at the next load_en cycle. scan_ptr is retained while in MANUAL mode and is never modified there.
- Simultaneous out_ready=1 and a new eligible channel: the old word is consumed and the new word is captured in the same edge (full throughput, one word per cycle).
- Reset asserted mid-transfer: the held word is discarded and no in_ready is asserted while reset=0.

Decomposition:
- Package mux_seq_pkg:
  - constants MODE_MANUAL=1'b0, MODE_SCAN=1'b1
  - clog2 function (result minimum 1)
- One sub-module, rr_pick: combinational cyclic priority search. It takes the eligible vector and scan_ptr and returns found and index. The top level holds all registers and the load_en/in_ready logic.

Test Plan:
(All tests use WIDTH=8, INPUTS=5, RESET_VALUE=8'hA5.)
1. Reset: reset=0 mid-run with out_valid=1 -> out=8'hA5, out_valid=0, out_channel=0 immediately, without waiting for a clock edge. After release, the first capture is from the channel selected by the post-reset state.
2. MANUAL: select=3, in[3]=8'h3C, all valid, mask=5'h1F, out_ready=1 -> in_ready=5'b01000 that cycle; next cycle out=8'h3C, out_channel=3, out_valid=1.
3. MANUAL out-of-range: select=6 -> next cycle select_error=1 for exactly one cycle, out_valid=0, out holds its previous value, in_ready=0.
4. SCAN fairness: all valid, mask=5'b10101, out_ready=1 -> out_channel sequence 0,2,4,0,2 on consecutive cycles; channels 1 and 3 are never selected.
5. Backpressure: SCAN, out_ready=0 for 3 cycles after a capture of channel 2 -> out and out_channel hold, in_ready=0, scan_ptr=3 held. Then out_ready=1 -> next capture is channel 3 if eligible.
6. Empty: in_valid=0 in SCAN -> out_valid drops to 0, scan_ptr is unchanged. Then in_valid=5'b00001 -> channel 0 is captured after one cycle.
